// File: rtl/gradient_controller.sv
// Sobel front-end controller: assembles a 3x3 window from streamed columns, hands it to
// the gradient units and emits min(gx+gy,255), or a binary edge when SOBEL_THRESHOLD_EN is defined.
module gradient_controller #(
  parameter int unsigned EDGE_THRESH = 128
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             col_valid,
  input  logic [23:0]      col_pixels,
  input  logic             row_start,
  output logic             col_ready,
  output logic [8:0][7:0]  window_buffer,
  output logic             start_calculations,
  input  logic             h_done,
  input  logic             v_done,
  input  logic [10:0]      gx,
  input  logic [10:0]      gy,
  output logic             edge_valid,
  output logic [7:0]       edge_pixel,
  input  logic             edge_ready
);

  typedef enum logic [1:0] {IDLE, FILL, CALC, OUTPUT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_fill_cnt;
  logic [8:0][7:0]  r_win;
  logic             r_h_seen;
  logic             r_v_seen;
  logic [10:0]      r_gx;
  logic [10:0]      r_gy;
  logic             r_edge_valid;
  logic [7:0]       r_edge_pixel;

  logic             w_col_ready;
  logic             w_start;
  logic             w_load;
  logic [1:0]       w_fill_next;
  logic             w_h_any;
  logic             w_v_any;
  logic             w_both;
  logic [11:0]      w_sum;
  logic [7:0]       w_pix;

  assign w_col_ready = (r_state == IDLE) || (r_state == FILL);
  // In IDLE only a row-starting column is taken into the window; others are dropped.
  assign w_load      = col_valid && w_col_ready && ((r_state == FILL) || row_start);
  assign w_fill_next = row_start ? 2'd1 : ((r_fill_cnt == 2'd3) ? 2'd3 : r_fill_cnt + 2'd1);
  assign w_h_any     = r_h_seen | h_done;
  assign w_v_any     = r_v_seen | v_done;
  assign w_both      = w_h_any & w_v_any;
  assign w_sum       = {1'b0, r_gx} + {1'b0, r_gy};

`ifdef SOBEL_THRESHOLD_EN
  assign w_pix = (w_sum >= 12'(EDGE_THRESH)) ? 8'hFF : 8'h00;
`else
  assign w_pix = (w_sum > 12'd255) ? 8'hFF : w_sum[7:0];
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE, FILL: begin
        if (w_load) w_next = (w_fill_next == 2'd3) ? CALC : FILL;
      end
      CALC: begin
        w_start = 1'b1;
        if (w_both) w_next = OUTPUT;
      end
      OUTPUT: begin
        if (r_edge_valid && edge_ready) w_next = FILL;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_fill_cnt   <= '0;
      r_win        <= '0;
      r_h_seen     <= 1'b0;
      r_v_seen     <= 1'b0;
      r_gx         <= '0;
      r_gy         <= '0;
      r_edge_valid <= 1'b0;
      r_edge_pixel <= '0;
    end else begin
      if (w_load) begin
        for (int unsigned r = 0; r < 3; r++) begin
          r_win[r*3]     <= r_win[r*3 + 1];
          r_win[r*3 + 1] <= r_win[r*3 + 2];
        end
        r_win[2]   <= col_pixels[23:16];
        r_win[5]   <= col_pixels[15:8];
        r_win[8]   <= col_pixels[7:0];
        r_fill_cnt <= w_fill_next;
      end
      if (r_state == CALC) begin
        if (h_done && !r_h_seen) r_gx <= gx;
        if (v_done && !r_v_seen) r_gy <= gy;
        r_h_seen <= w_both ? 1'b0 : w_h_any;
        r_v_seen <= w_both ? 1'b0 : w_v_any;
      end
      // First OUTPUT cycle registers the result; it is then held until accepted.
      if (r_state == OUTPUT) begin
        if (!r_edge_valid) begin
          r_edge_valid <= 1'b1;
          r_edge_pixel <= w_pix;
        end else if (edge_ready) begin
          r_edge_valid <= 1'b0;
        end
      end
    end
  end

  assign col_ready          = w_col_ready;
  assign start_calculations = w_start;
  assign window_buffer      = r_win;
  assign edge_valid         = r_edge_valid;
  assign edge_pixel         = r_edge_pixel;

endmodule

// File: tb/tb_gradient_controller.sv
// Bench for gradient_controller: directed scenarios with literal expectations, then random
// traffic checked every cycle against a column-history model of the controller.
module tb_gradient_controller;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            col_valid = 1'b0;
  logic [23:0]     col_pixels = '0;
  logic            row_start = 1'b0;
  logic            h_done = 1'b0;
  logic            v_done = 1'b0;
  logic [10:0]     gx = '0;
  logic [10:0]     gy = '0;
  logic            edge_ready = 1'b1;
  logic            col_ready;
  logic            start_calculations;
  logic            edge_valid;
  logic [7:0]      edge_pixel;
  logic [8:0][7:0] window_buffer;

  always #5 clk = ~clk;

  gradient_controller #(.EDGE_THRESH(128)) dut (
    .clk(clk), .n_rst(n_rst), .col_valid(col_valid), .col_pixels(col_pixels),
    .row_start(row_start), .col_ready(col_ready), .window_buffer(window_buffer),
    .start_calculations(start_calculations), .h_done(h_done), .v_done(v_done),
    .gx(gx), .gy(gy), .edge_valid(edge_valid), .edge_pixel(edge_pixel),
    .edge_ready(edge_ready)
  );

`ifdef SOBEL_THRESHOLD_EN
  localparam int EXP_85 = 0, EXP_110 = 0, EXP_30 = 0;
`else
  localparam int EXP_85 = 85, EXP_110 = 110, EXP_30 = 30;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_edge(input int a, input int b);
`ifdef SOBEL_THRESHOLD_EN
    return (a + b >= 128) ? 255 : 0;
`else
    return (a + b > 255) ? 255 : a + b;
`endif
  endfunction

  // Reference model: window = last three accepted columns since reset.
  logic [23:0] m_hist[$];
  int  m_row_len = 0, m_phase = 0, m_calc_idx = 0, m_gx = 0, m_gy = 0, m_ep = 0;
  bit  m_hs = 0, m_vs = 0, m_ev = 0, m_chk = 0;

  function automatic logic [8:0][7:0] m_window();
    logic [8:0][7:0] w;
    logic [23:0]     c;
    int              k;
    w = '0;
    for (int col = 0; col < 3; col++) begin
      k = m_hist.size() - 3 + col;
      c = (k >= 0) ? m_hist[k] : 24'h0;
      w[col]     = c[23:16];
      w[3 + col] = c[15:8];
      w[6 + col] = c[7:0];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      m_hist.delete();
      m_row_len = 0; m_phase = 0; m_calc_idx = 0;
      m_hs = 0; m_vs = 0; m_gx = 0; m_gy = 0; m_ev = 0; m_ep = 0; m_chk = 1;
    end else begin
      case (m_phase)
        0, 1: if (col_valid && (m_phase == 1 || row_start)) begin
          m_hist.push_back(col_pixels);
          if (m_hist.size() > 3) void'(m_hist.pop_front());
          m_row_len  = row_start ? 1 : ((m_row_len < 3) ? m_row_len + 1 : 3);
          m_phase    = (m_row_len == 3) ? 2 : 1;
          m_calc_idx = 0;
        end
        2: begin
          if (h_done && !m_hs) begin m_gx = int'(gx); m_hs = 1; end
          if (v_done && !m_vs) begin m_gy = int'(gy); m_vs = 1; end
          if (m_hs && m_vs) begin m_phase = 3; m_hs = 0; m_vs = 0; end
          else m_calc_idx++;
        end
        default: begin
          if (!m_ev) begin m_ev = 1; m_ep = exp_edge(m_gx, m_gy); end
          else if (edge_ready) begin m_ev = 0; m_phase = 1; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_chk) begin
      chk("col_ready", 72'(col_ready), 72'(m_phase <= 1));
      chk("start_calculations", 72'(start_calculations), 72'(m_phase == 2));
      chk("edge_valid", 72'(edge_valid), 72'(m_ev));
      if (m_ev) chk("edge_pixel", 72'(edge_pixel), 72'(m_ep));
      chk("window_buffer", window_buffer, m_window());
    end
  end

  // Gradient-unit stand-in: done flags follow the planned per-window delays.
  bit rand_mode = 0;
  int p_hd = 0, p_vd = 0, p_gx = 0, p_gy = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (m_phase == 2) begin
        if (rand_mode && m_calc_idx == 0) begin
          p_hd = $urandom_range(0, 3);
          p_vd = $urandom_range(0, 3);
          p_gx = $urandom_range(0, 1) ? $urandom_range(0, 2047) : $urandom_range(0, 150);
          p_gy = $urandom_range(0, 1) ? $urandom_range(0, 2047) : $urandom_range(0, 150);
        end
        h_done = (m_calc_idx >= p_hd);
        v_done = (m_calc_idx >= p_vd);
        gx = (m_calc_idx == p_hd) ? 11'(p_gx) : 11'($urandom_range(0, 2047));
        gy = (m_calc_idx == p_vd) ? 11'(p_gy) : 11'($urandom_range(0, 2047));
      end else begin
        h_done = 1'b0;
        v_done = 1'b0;
        gx = 11'($urandom_range(0, 2047));
        gy = 11'($urandom_range(0, 2047));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [23:0] col, input logic rs);
    col_valid = 1'b1; row_start = rs; col_pixels = col;
    tick();
    col_valid = 1'b0; row_start = 1'b0;
  endtask

  task automatic wait_ev();
    int n;
    n = 0;
    while (!edge_valid && n < 20) begin tick(); n++; end
    if (!edge_valid) chk("edge_valid_timeout", 72'(edge_valid), 72'(1));
  endtask

  logic [8:0][7:0] exp_w;
  int sc;

  initial begin
    // Reset
    n_rst = 1'b0;
    repeat (2) tick();
    chk("rst_col_ready", 72'(col_ready), 72'(1));
    chk("rst_start", 72'(start_calculations), 72'(0));
    chk("rst_edge_valid", 72'(edge_valid), 72'(0));
    chk("rst_edge_pixel", 72'(edge_pixel), 72'(0));
    chk("rst_window", window_buffer, 72'(0));
    n_rst = 1'b1;

    // Basic flow, done on the first CALC cycle
    p_hd = 0; p_vd = 0; p_gx = 30; p_gy = 55;
    push(24'h326464, 1'b1);
    push(24'hFF00FF, 1'b0);
    push(24'hFAC8FF, 1'b0);
    exp_w[0] = 8'd50;  exp_w[1] = 8'd255; exp_w[2] = 8'd250;
    exp_w[3] = 8'd100; exp_w[4] = 8'd0;   exp_w[5] = 8'd200;
    exp_w[6] = 8'd100; exp_w[7] = 8'd255; exp_w[8] = 8'd255;
    chk("basic_window", window_buffer, exp_w);
    chk("basic_start", 72'(start_calculations), 72'(1));
    tick();
    chk("basic_ev_after1", 72'(edge_valid), 72'(0));
    tick();
    chk("basic_ev_after2", 72'(edge_valid), 72'(1));
    chk("basic_pixel", 72'(edge_pixel), 72'(EXP_85));
    tick();
    chk("basic_ev_drop", 72'(edge_valid), 72'(0));
    chk("basic_ready_back", 72'(col_ready), 72'(1));

    // Saturation and zero
    p_gx = 200; p_gy = 100;
    push(24'h010203, 1'b0);
    wait_ev();
    chk("sat_pixel", 72'(edge_pixel), 72'(255));
    tick();
    p_gx = 0; p_gy = 0;
    push(24'h040506, 1'b0);
    wait_ev();
    chk("zero_pixel", 72'(edge_pixel), 72'(0));
    tick();

    // Skewed done: h on cycle 1, v on cycle 3
    p_hd = 0; p_vd = 2; p_gx = 40; p_gy = 70;
    push(24'h070809, 1'b0);
    sc = 0;
    while (start_calculations && sc < 20) begin sc++; tick(); end
    chk("skew_start_cycles", 72'(sc), 72'(3));
    wait_ev();
    chk("skew_pixel", 72'(edge_pixel), 72'(EXP_110));
    tick();

    // Backpressure
    edge_ready = 1'b0;
    p_hd = 1; p_vd = 0; p_gx = 10; p_gy = 20;
    push(24'h0A0B0C, 1'b0);
    wait_ev();
    for (int i = 0; i < 4; i++) begin
      col_valid = 1'b1; col_pixels = 24'hABCDEF;
      tick();
      chk("bp_edge_valid", 72'(edge_valid), 72'(1));
      chk("bp_pixel", 72'(edge_pixel), 72'(EXP_30));
      chk("bp_col_ready", 72'(col_ready), 72'(0));
    end
    col_valid = 1'b0;
    edge_ready = 1'b1;
    tick();
    chk("bp_release", 72'(edge_valid), 72'(0));
    p_hd = 9; p_vd = 9;
    push(24'h112233, 1'b0);
    exp_w[0] = 8'h07; exp_w[1] = 8'h0A; exp_w[2] = 8'h11;
    exp_w[3] = 8'h08; exp_w[4] = 8'h0B; exp_w[5] = 8'h22;
    exp_w[6] = 8'h09; exp_w[7] = 8'h0C; exp_w[8] = 8'h33;
    chk("next_window", window_buffer, exp_w);
    chk("next_start", 72'(start_calculations), 72'(1));

    // Reset in the middle of CALC
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("midrst_start", 72'(start_calculations), 72'(0));
    chk("midrst_col_ready", 72'(col_ready), 72'(1));
    chk("midrst_window", window_buffer, 72'(0));
    push(24'h445566, 1'b0);
    chk("idle_discard_window", window_buffer, 72'(0));
    chk("idle_discard_start", 72'(start_calculations), 72'(0));

    // Random traffic
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      col_valid  = ($urandom_range(0, 9) < 6);
      row_start  = ($urandom_range(0, 9) < 2);
      col_pixels = 24'($urandom);
      edge_ready = ($urandom_range(0, 9) < 7);
      n_rst      = ($urandom_range(0, 399) != 0);
      tick();
    end
    n_rst = 1'b1; col_valid = 1'b0;
    tick();
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
